// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle for the hazard/forwarding controller: ID fields and
// operand sources in, pipeline control and forwarded operands out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RA_W   = 3,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned SEL_W  = 2
);
  logic                    id_valid;
  logic                    id_two_word;
  logic [RA_W-1:0]         id_rs1;
  logic [RA_W-1:0]         id_rs2;
  logic                    id_use1;
  logic                    id_use2;
  logic [RA_W-1:0]         id_rd;
  logic                    id_wr;
  logic                    id_load;
  logic [DATA_W-1:0]       rf_op1;
  logic [DATA_W-1:0]       rf_op2;
  logic [DEPTH*DATA_W-1:0] stage_data;
  logic                    flush;
  logic                    stall;
  logic                    bubble;
  logic                    hold_instr;
  logic                    imm_phase;
  logic [SEL_W-1:0]        op1_sel;
  logic [SEL_W-1:0]        op2_sel;
  logic [DATA_W-1:0]       op1_out;
  logic [DATA_W-1:0]       op2_out;
  logic [15:0]             stall_cnt;

  modport master (
    output id_valid, id_two_word, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr, id_load,
    output rf_op1, rf_op2, stage_data, flush,
    input  stall, bubble, hold_instr, imm_phase, op1_sel, op2_sel, op1_out, op2_out, stall_cnt
  );

  modport slave (
    input  id_valid, id_two_word, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr, id_load,
    input  rf_op1, rf_op2, stage_data, flush,
    output stall, bubble, hold_instr, imm_phase, op1_sel, op2_sel, op1_out, op2_out, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller beside the decode stage: tracks in-flight
// destinations, stalls on load-use, forwards operands and sequences two-word
// instructions through an immediate phase.
module pipe_hazard_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RA_W       = 3,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned SEL_W      = 2
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {StRun, StImm} state_e;

  state_e state_q, state_d;

  // Tracker entry k describes the instruction k stages past ID
  logic [DEPTH:1]  trk_v_q, trk_wr_q, trk_ld_q;
  logic [RA_W-1:0] trk_rd_q [DEPTH:1];

  // First word of a two-word instruction, held while the immediate is in IF/ID
  logic [RA_W-1:0] lat_rs1_q, lat_rs2_q, lat_rd_q;
  logic            lat_use1_q, lat_use2_q, lat_wr_q, lat_ld_q;
  logic            latch_en, latch_clr;

  logic [RA_W-1:0]   cur_rs1, cur_rs2, cur_rd;
  logic              cur_use1, cur_use2, cur_wr, cur_ld;
  logic              hazard, issue, stall, bubble, hold_instr, imm_phase;
  logic [SEL_W-1:0]  sel1, sel2;
  logic [DATA_W-1:0] op1, op2;
  logic [15:0]       stall_cnt_q;

  // Select the fields of the instruction currently being decided
  always_comb begin
    cur_rs1  = bus.id_rs1;
    cur_rs2  = bus.id_rs2;
    cur_use1 = bus.id_use1;
    cur_use2 = bus.id_use2;
    cur_rd   = bus.id_rd;
    cur_wr   = bus.id_wr;
    cur_ld   = bus.id_load;
    if (state_q == StImm) begin
      cur_rs1  = lat_rs1_q;
      cur_rs2  = lat_rs2_q;
      cur_use1 = lat_use1_q;
      cur_use2 = lat_use2_q;
      cur_rd   = lat_rd_q;
      cur_wr   = lat_wr_q;
      cur_ld   = lat_ld_q;
    end
  end

  // Match sources against tracked stages; youngest non-hazard match forwards
  always_comb begin
    logic m1, m2, hz, found1, found2;
    hazard = 1'b0;
    sel1   = '0;
    sel2   = '0;
    found1 = 1'b0;
    found2 = 1'b0;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      m1 = trk_v_q[k] & trk_wr_q[k] & (trk_rd_q[k] == cur_rs1) & cur_use1;
      m2 = trk_v_q[k] & trk_wr_q[k] & (trk_rd_q[k] == cur_rs2) & cur_use2;
      hz = trk_ld_q[k] & (k < int'(LOAD_STAGE));
      if ((m1 | m2) & hz) hazard = 1'b1;
      if (m1 & ~hz & ~found1) begin
        sel1   = SEL_W'(k);
        found1 = 1'b1;
      end
      if (m2 & ~hz & ~found2) begin
        sel2   = SEL_W'(k);
        found2 = 1'b1;
      end
    end
  end

  // Operand muxes: register file unless a stage is selected
  always_comb begin
    op1 = bus.rf_op1;
    op2 = bus.rf_op2;
    for (int k = 1; k <= int'(DEPTH); k++) begin
      if (sel1 == SEL_W'(k)) op1 = bus.stage_data[(k-1)*DATA_W +: DATA_W];
      if (sel2 == SEL_W'(k)) op2 = bus.stage_data[(k-1)*DATA_W +: DATA_W];
    end
  end

  // Next state and pipeline controls; flush dominates everything
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    bubble     = 1'b1;
    hold_instr = 1'b0;
    imm_phase  = 1'b0;
    issue      = 1'b0;
    latch_en   = 1'b0;
    latch_clr  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.flush) begin
          latch_clr = 1'b1;
        end else if (bus.id_valid & bus.id_two_word) begin
          // First word never issues; it goes down the pipe with the immediate
          latch_en   = 1'b1;
          hold_instr = 1'b1;
          state_d    = StImm;
        end else begin
          issue  = bus.id_valid & ~hazard;
          bubble = ~issue;
          stall  = hazard & bus.id_valid;
        end
      end
      StImm: begin
        imm_phase = 1'b1;
        if (bus.flush) begin
          latch_clr = 1'b1;
          state_d   = StRun;
        end else if (hazard) begin
          stall = 1'b1;
        end else begin
          issue   = 1'b1;
          bubble  = 1'b0;
          state_d = StRun;
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StRun;
    else     state_q <= state_d;
  end

  // Two-word latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst || latch_clr) begin
      {lat_rs1_q, lat_rs2_q, lat_rd_q} <= '0;
      {lat_use1_q, lat_use2_q, lat_wr_q, lat_ld_q} <= '0;
    end else if (latch_en) begin
      lat_rs1_q  <= bus.id_rs1;
      lat_rs2_q  <= bus.id_rs2;
      lat_rd_q   <= bus.id_rd;
      lat_use1_q <= bus.id_use1;
      lat_use2_q <= bus.id_use2;
      lat_wr_q   <= bus.id_wr;
      lat_ld_q   <= bus.id_load;
    end
  end

  // Tracker shift: downstream stages never stall, so entries always advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_v_q  <= '0;
      trk_wr_q <= '0;
      trk_ld_q <= '0;
      for (int k = 1; k <= int'(DEPTH); k++) trk_rd_q[k] <= '0;
    end else begin
      trk_v_q[1]  <= issue;
      trk_rd_q[1] <= cur_rd;
      trk_wr_q[1] <= cur_wr;
      trk_ld_q[1] <= cur_ld;
      for (int k = 2; k <= int'(DEPTH); k++) begin
        trk_v_q[k]  <= trk_v_q[k-1];
        trk_rd_q[k] <= trk_rd_q[k-1];
        trk_wr_q[k] <= trk_wr_q[k-1];
        trk_ld_q[k] <= trk_ld_q[k-1];
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1)    stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign bus.stall      = stall;
  assign bus.bubble     = bubble;
  assign bus.hold_instr = hold_instr;
  assign bus.imm_phase  = imm_phase;
  assign bus.op1_sel    = sel1;
  assign bus.op2_sel    = sel2;
  assign bus.op1_out    = op1;
  assign bus.op2_out    = op2;
  assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Instance A uses the default pipeline
// (DEPTH=3, LOAD_STAGE=2); instance B (DEPTH=4, LOAD_STAGE=4) exercises a
// hazard held across the immediate phase. Expectations go to a scoreboard
// queue and a monitor compares them against the selected instance.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b1;
  logic rst;
  logic probe = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.DATA_W(16), .RA_W(3), .DEPTH(3), .SEL_W(2)) ifa ();
  pipe_hazard_ctrl_if #(.DATA_W(16), .RA_W(3), .DEPTH(4), .SEL_W(3)) ifb ();

  pipe_hazard_ctrl #(.DATA_W(16), .RA_W(3), .DEPTH(3), .LOAD_STAGE(2), .SEL_W(2)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  pipe_hazard_ctrl #(.DATA_W(16), .RA_W(3), .DEPTH(4), .LOAD_STAGE(4), .SEL_W(3)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  typedef struct {
    string       nm;
    bit          b;
    logic        st, bu, ho, im;
    logic [31:0] s1, s2;
    logic [15:0] o1, o2, cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [15:0] opv(int s, logic [15:0] rf);
    case (s)
      0:       return rf;
      1:       return 16'h1111;
      2:       return 16'h2222;
      3:       return 16'h3333;
      default: return 16'h4444;
    endcase
  endfunction

  function automatic void chk(string nm, string f, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, f, got, want);
    end
  endfunction

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(bit v, bit tw, int rs1, bit u1, int rs2, bit u2, int rd, bit wr, bit ld,
                     bit fl);
    ifa.id_valid = v;  ifa.id_two_word = tw; ifa.id_rs1 = 3'(rs1); ifa.id_use1 = u1;
    ifa.id_rs2 = 3'(rs2); ifa.id_use2 = u2; ifa.id_rd = 3'(rd); ifa.id_wr = wr;
    ifa.id_load = ld;  ifa.flush = fl;
    ifb.id_valid = v;  ifb.id_two_word = tw; ifb.id_rs1 = 3'(rs1); ifb.id_use1 = u1;
    ifb.id_rs2 = 3'(rs2); ifb.id_use2 = u2; ifb.id_rd = 3'(rd); ifb.id_wr = wr;
    ifb.id_load = ld;  ifb.flush = fl;
  endtask

  task automatic expect_out(string nm, bit b, bit st, bit bu, bit ho, bit im, int s1, int s2,
                            int cnt);
    exp_t e;
    e.nm = nm; e.b = b; e.st = st; e.bu = bu; e.ho = ho; e.im = im;
    e.s1 = 32'(s1); e.s2 = 32'(s2);
    e.o1 = opv(s1, 16'hAAAA); e.o2 = opv(s2, 16'hBBBB); e.cnt = 16'(cnt);
    sb.push_back(e);
  endtask

  // Monitor: one expectation per sample point
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge probe);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.b) begin
          chk(e.nm, "stall", 32'(ifb.stall), 32'(e.st));
          chk(e.nm, "bubble", 32'(ifb.bubble), 32'(e.bu));
          chk(e.nm, "hold", 32'(ifb.hold_instr), 32'(e.ho));
          chk(e.nm, "imm", 32'(ifb.imm_phase), 32'(e.im));
          chk(e.nm, "sel1", 32'(ifb.op1_sel), e.s1);
          chk(e.nm, "sel2", 32'(ifb.op2_sel), e.s2);
          chk(e.nm, "op1", 32'(ifb.op1_out), 32'(e.o1));
          chk(e.nm, "op2", 32'(ifb.op2_out), 32'(e.o2));
          chk(e.nm, "cnt", 32'(ifb.stall_cnt), 32'(e.cnt));
        end else begin
          chk(e.nm, "stall", 32'(ifa.stall), 32'(e.st));
          chk(e.nm, "bubble", 32'(ifa.bubble), 32'(e.bu));
          chk(e.nm, "hold", 32'(ifa.hold_instr), 32'(e.ho));
          chk(e.nm, "imm", 32'(ifa.imm_phase), 32'(e.im));
          chk(e.nm, "sel1", 32'(ifa.op1_sel), e.s1);
          chk(e.nm, "sel2", 32'(ifa.op2_sel), e.s2);
          chk(e.nm, "op1", 32'(ifa.op1_out), 32'(e.o1));
          chk(e.nm, "op2", 32'(ifa.op2_out), 32'(e.o2));
          chk(e.nm, "cnt", 32'(ifa.stall_cnt), 32'(e.cnt));
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    ifa.rf_op1 = 16'hAAAA; ifa.rf_op2 = 16'hBBBB; ifa.stage_data = 48'h3333_2222_1111;
    ifb.rf_op1 = 16'hAAAA; ifb.rf_op2 = 16'hBBBB; ifb.stage_data = 64'h4444_3333_2222_1111;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset", 0, 0, 1, 0, 0, 0, 0, 0);
    #7 rst = 1'b0;

    // Back-to-back ALU: R1=R2+R3 then R4=R1+R1
    go(); drv(1, 0, 2, 1, 3, 1, 1, 1, 0, 0); expect_out("alu1", 0, 0, 0, 0, 0, 0, 0, 0);
    go(); drv(1, 0, 1, 1, 1, 1, 4, 1, 0, 0); expect_out("alu2_fwd", 0, 0, 0, 0, 0, 1, 1, 0);

    // Load-use: LDD R2 then ADD R5,R2,R3
    go(); drv(1, 0, 0, 0, 0, 0, 2, 1, 1, 0); expect_out("ldd", 0, 0, 0, 0, 0, 0, 0, 0);
    go(); drv(1, 0, 2, 1, 3, 1, 5, 1, 0, 0); expect_out("lu_stall", 0, 1, 1, 0, 0, 0, 0, 0);
    go();                                    expect_out("lu_mem", 0, 0, 0, 0, 0, 2, 0, 1);

    // Priority: R1 in EX and WB, R7 untracked; then WB/MEM forwarding
    go(); drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); expect_out("wr_r1a", 0, 0, 0, 0, 0, 0, 0, 1);
    go(); drv(1, 0, 0, 0, 0, 0, 6, 1, 0, 0); expect_out("wr_r6", 0, 0, 0, 0, 0, 0, 0, 1);
    go(); drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); expect_out("wr_r1b", 0, 0, 0, 0, 0, 0, 0, 1);
    go(); drv(1, 0, 1, 1, 7, 1, 0, 0, 0, 0); expect_out("prio", 0, 0, 0, 0, 0, 1, 0, 1);
    go(); drv(1, 0, 6, 1, 1, 1, 0, 0, 0, 0); expect_out("wb_mem", 0, 0, 0, 0, 0, 3, 2, 1);

    // Two-word LDM R3,#0x00AB; ID fields during the immediate must be ignored
    go(); drv(1, 1, 0, 0, 0, 0, 3, 1, 0, 0); expect_out("ldm_w1", 0, 0, 1, 1, 0, 0, 0, 1);
    go(); drv(1, 1, 3, 1, 3, 1, 7, 1, 1, 0); expect_out("ldm_imm", 0, 0, 0, 0, 1, 0, 0, 1);
    go(); drv(1, 0, 3, 1, 3, 1, 5, 1, 0, 0); expect_out("ldm_use", 0, 0, 0, 0, 0, 1, 1, 1);

    // Flush during the immediate phase
    go(); drv(1, 1, 0, 0, 0, 0, 6, 1, 0, 0); expect_out("fl_w1", 0, 0, 1, 1, 0, 0, 0, 1);
    go(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expect_out("fl_imm", 0, 0, 1, 0, 1, 0, 0, 1);
    go(); drv(1, 0, 6, 1, 5, 1, 0, 0, 0, 0); expect_out("fl_after", 0, 0, 0, 0, 0, 0, 3, 1);

    // Build up stall count with repeated load-use pairs
    for (int i = 0; i < 4; i++) begin
      go(); drv(1, 0, 0, 0, 0, 0, 2, 1, 1, 0); expect_out("rep_ld", 0, 0, 0, 0, 0, 0, 0, 1 + i);
      go(); drv(1, 0, 2, 1, 0, 0, 0, 0, 0, 0); expect_out("rep_st", 0, 1, 1, 0, 0, 0, 0, 1 + i);
      go();                                    expect_out("rep_go", 0, 0, 0, 0, 0, 2, 0, 2 + i);
    end
    go(); drv(1, 0, 0, 0, 0, 0, 2, 1, 1, 0); expect_out("pre_rst_ld", 0, 0, 0, 0, 0, 0, 0, 5);
    go(); drv(1, 0, 2, 1, 0, 0, 0, 0, 0, 0); expect_out("pre_rst_st", 0, 1, 1, 0, 0, 0, 0, 5);

    // Reset mid-stall, sampled before any clock edge
    @(negedge clk);
    #1 rst = 1'b1;
    expect_out("rst_async", 0, 0, 0, 0, 0, 0, 0, 0);
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    #1 rst = 1'b0;
    go(); drv(1, 0, 2, 1, 5, 1, 0, 0, 0, 0); expect_out("rst_trk", 0, 0, 0, 0, 0, 0, 0, 0);

    // Instance B: load hazard persists into the immediate phase, then flush
    go(); drv(1, 0, 0, 0, 0, 0, 4, 1, 1, 0); expect_out("b_ldd", 1, 0, 0, 0, 0, 0, 0, 0);
    go(); drv(1, 1, 4, 1, 0, 0, 6, 1, 0, 0); expect_out("b_w1", 1, 0, 1, 1, 0, 0, 0, 0);
    go(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("b_imm_st", 1, 1, 1, 0, 1, 0, 0, 0);
    go(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); expect_out("b_imm_fl", 1, 0, 1, 0, 1, 0, 0, 1);
    go(); drv(1, 0, 4, 1, 6, 1, 0, 0, 0, 0); expect_out("b_after", 1, 0, 0, 0, 0, 4, 0, 1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the 16-bit in-order pipeline (IF, ID, EX, MEM, WB and deeper variants).
It tracks destination registers of in-flight instructions and stalls on load-use hazards.
It forwards operands from any downstream stage to ID/EX and sequences two-word (LDM-style) instructions.
It sits beside the decode stage and drives the IF/ID and ID/EX register enables and operand muxes.

Parameters:
DATA_W, 16, operand width
RA_W, 3, register address width (2**RA_W architectural registers, no hard-wired zero)
DEPTH, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB, ...)
LOAD_STAGE, 2, first tracked stage where load data can be forwarded (1 <= LOAD_STAGE <= DEPTH)
SEL_W, 2, forward-select width, >= clog2(DEPTH+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a valid instruction word
id_two_word  in  1  instruction needs a following immediate word
id_rs1, id_rs2  in  RA_W each  source register addresses
id_use1, id_use2  in  1 each  source actually read
id_rd  in  RA_W  destination address
id_wr  in  1  instruction writes a register
id_load  in  1  instruction is a memory load
rf_op1, rf_op2  in  DATA_W each  register-file read data
stage_data  in  DEPTH*DATA_W  result of tracked stage k, in slice [(k-1)*DATA_W +: DATA_W]
flush  in  1  kill the instruction in ID (branch/redirect)
stall  out  1  hold PC and IF/ID
bubble  out  1  load NOP into ID/EX
hold_instr  out  1  external latch captures the first word of a two-word instruction
imm_phase  out  1  IF/ID currently holds the immediate word
op1_sel, op2_sel  out  SEL_W each  0=register file, k=stage k
op1_out, op2_out  out  DATA_W each  forwarded operands
stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-high. On reset, all tracker entries are invalid, the FSM is in RUN, the latched fields are cleared and stall_cnt=0.
- Outputs after reset: combinational outputs follow from the cleared state. With id_valid=0: stall=0, bubble=1, hold_instr=0, imm_phase=0, selects=0, op_out=rf_op.
- Tracker: trk[1..DEPTH] = {v, rd, wr, ld}. Every cycle trk[k] <= trk[k-1] for k>=2, with no stall of downstream stages. trk[1] <= issue ? current fields : invalid.
- Current fields: the id_* inputs in RUN; the latched copy in IMM.
- Match, per source s: trk[k].v & trk[k].wr & trk[k].rd==rs_s & use_s.
- Hazard: any match with trk[k].ld=1 and k<LOAD_STAGE.
- Forwarding: sel_s = the smallest k with a match that is not a hazard; 0 if none. op_out = the selected stage_data slice, else rf_op.
- Forwarding is combinational, with zero latency.
- issue = valid_cur & ~hazard & ~flush, where valid_cur = id_valid in RUN and 1 in IMM.
- FSM RUN:
  - id_valid & id_two_word & ~flush: latch the fields, hold_instr=1, bubble=1, stall=0, go to IMM. IF/ID advances to the immediate.
  - Otherwise: bubble = ~issue; stall = hazard & id_valid & ~flush.
- FSM IMM:
  - imm_phase=1.
  - If hazard & ~flush: stall=1, bubble=1, stay in IMM.
  - Else: issue the latched fields, bubble=0, stall=0, return to RUN.
- flush: highest priority. It forces stall=0, bubble=1, no issue, and next state RUN. It clears the latch. Older tracker entries are unaffected.
- stall_cnt increments on each cycle with stall=1 and saturates at 16'hFFFF.
- Reset mid-operation: asynchronous return to the reset state, including during IMM.

Test Plan:
- Back-to-back ALU (LOAD_STAGE=2): R1=R2+R3, then R4=R1+R1 -> 2nd cycle op1_sel=op2_sel=1, op1_out=stage_data slice0, no stall.
- Load-use: LDD R2, then ADD R5,R2,R3 -> exactly 1 cycle stall=1 and bubble=1. Next cycle op1_sel=2 (MEM), stall_cnt=1.
- Priority: R1 written in both EX and WB, consumer reads R1 -> op1_sel=1, not 3. Unrelated source R7 -> op2_sel=0, op2_out=rf_op2.
- Two-word LDM R3,#0x00AB -> hold_instr=1 and bubble=1 on cycle 1. imm_phase=1 on cycle 2, issuing rd=3. Next consumer of R3 forwarded from EX.
- flush during IMM with a pending hazard -> same cycle stall=0, bubble=1. Next state RUN, trk[1] invalid, imm_phase=0.
- rst asserted mid-stall with stall_cnt=5 -> immediately stall_cnt=0, all tracker entries invalid, stall=0.
